// File: rtl/cam_frame_crop_if.sv
// Pixel stream interface for cam_frame_crop: the qualified camera input stream,
// the cropped SOF/EOL-tagged output stream and the per-frame geometry report.
interface cam_frame_crop_if #(
  parameter int CW = 12
);
  logic          in_vsync;
  logic          in_href;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_sof;
  logic          out_eol;
  logic [CW-1:0] meas_width;
  logic [CW-1:0] meas_height;
  logic          meas_update;
  logic          frame_err;

  modport master (
    output in_vsync, in_href, in_valid, in_data,
    input  out_valid, out_data, out_sof, out_eol,
    input  meas_width, meas_height, meas_update, frame_err
  );

  modport slave (
    input  in_vsync, in_href, in_valid, in_data,
    output out_valid, out_data, out_sof, out_eol,
    output meas_width, meas_height, meas_update, frame_err
  );
endinterface

// File: rtl/cam_frame_crop.sv
// Crops a fixed window out of the RGB565 camera stream, tags it with SOF/EOL,
// and measures each incoming frame's width/height with a malformed-frame flag.
module cam_frame_crop #(
  parameter int X_START = 0,
  parameter int Y_START = 0,
  parameter int CROP_W  = 640,
  parameter int CROP_H  = 480,
  parameter int CW      = 12
) (
  input logic             cam_pclk,
  input logic             cam_data_asy_rst,
  cam_frame_crop_if.slave bus
);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  localparam int X_HI_I   = X_START + CROP_W;
  localparam int Y_HI_I   = Y_START + CROP_H;
  localparam int X_LAST_I = X_START + CROP_W - 1;

  localparam logic [CW:0]   X_LO   = X_START[CW:0];
  localparam logic [CW:0]   Y_LO   = Y_START[CW:0];
  localparam logic [CW:0]   X_SPAN = CROP_W[CW:0];
  localparam logic [CW:0]   Y_SPAN = CROP_H[CW:0];
  localparam logic [CW:0]   X_HI   = X_HI_I[CW:0];
  localparam logic [CW:0]   Y_HI   = Y_HI_I[CW:0];
  localparam logic [CW:0]   X_LAST = X_LAST_I[CW:0];
  localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  logic [1:0]    rst_sync_r;
  logic          rst;
  state_t        state_r, state_nxt;
  logic          valid_d_r, href_d_r;
  logic [CW-1:0] x_r, y_r, ref_w_r;
  logic          have_ref_r, line_err_r;
  logic          out_valid_r, out_sof_r, out_eol_r;
  logic [15:0]   out_data_r;
  logic [CW-1:0] meas_width_r, meas_height_r;
  logic          meas_update_r, frame_err_r;

  logic          active_s, taken_s, href_rise_s, line_end_s, line_done_s;
  logic          close_s, width_bad_s, err_eff_s, crop_hit_s, x_in_s, y_in_s;
  logic [CW-1:0] x_inc_s, x_eff_s, y_new_s, ref_eff_s;

  // Async assert, 2-flop synchronized release of the internal reset.
  always_ff @(posedge cam_pclk or posedge cam_data_asy_rst) begin
    if (cam_data_asy_rst) begin
      rst_sync_r <= 2'b11;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b0};
    end
  end

  assign rst = rst_sync_r[1];

  // Frame FSM state register.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_SOF;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Frame FSM next state: the first vsync arms the block, later ones close frames.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      WAIT_SOF: begin
        if (bus.in_vsync) begin
          state_nxt = ACTIVE;
        end else begin
          state_nxt = WAIT_SOF;
        end
      end
      ACTIVE:  state_nxt = ACTIVE;
      default: state_nxt = WAIT_SOF;
    endcase
  end

  // A line counts as finished when href falls, or when vsync cuts an open line short.
  always_comb begin
    active_s    = (state_r == ACTIVE);
    taken_s     = valid_d_r & active_s;
    href_rise_s = bus.in_href & ~href_d_r;
    line_end_s  = href_d_r & (~bus.in_href | bus.in_vsync);
    close_s     = active_s & bus.in_vsync;
    x_inc_s     = sat_inc(x_r);
    x_eff_s     = taken_s ? x_inc_s : x_r;
    line_done_s = active_s & line_end_s & (x_eff_s != ZERO);
    y_new_s     = line_done_s ? sat_inc(y_r) : y_r;
    width_bad_s = line_done_s & have_ref_r & (x_eff_s != ref_w_r);
    ref_eff_s   = (line_done_s & ~have_ref_r) ? x_eff_s : ref_w_r;
    err_eff_s   = line_err_r | width_bad_s;
    // Offset compare: positions left of the window wrap to huge values.
    x_in_s      = (({1'b0, x_r} - X_LO) < X_SPAN);
    y_in_s      = (({1'b0, y_r} - Y_LO) < Y_SPAN);
    crop_hit_s  = taken_s & x_in_s & y_in_s;
  end

  // Input qualifier delays used for pixel taking and href edge detection.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      valid_d_r <= 1'b0;
      href_d_r  <= 1'b0;
    end else begin
      valid_d_r <= bus.in_valid;
      href_d_r  <= bus.in_href;
    end
  end

  // Column/line counters and line-width consistency tracking.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      x_r        <= ZERO;
      y_r        <= ZERO;
      ref_w_r    <= ZERO;
      have_ref_r <= 1'b0;
      line_err_r <= 1'b0;
    end else if (bus.in_vsync) begin
      x_r        <= ZERO;
      y_r        <= ZERO;
      ref_w_r    <= ZERO;
      have_ref_r <= 1'b0;
      line_err_r <= 1'b0;
    end else if (active_s) begin
      if (href_rise_s) begin
        x_r <= ZERO;
      end else begin
        x_r <= x_eff_s;
      end
      y_r        <= y_new_s;
      ref_w_r    <= ref_eff_s;
      have_ref_r <= have_ref_r | line_done_s;
      line_err_r <= err_eff_s;
    end else begin
      x_r <= x_r;
    end
  end

  // Frame close: publish geometry of the frame that just ended.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      meas_width_r  <= ZERO;
      meas_height_r <= ZERO;
      meas_update_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      meas_update_r <= close_s;
      if (close_s) begin
        meas_width_r  <= ref_eff_s;
        meas_height_r <= y_new_s;
        frame_err_r   <= err_eff_s | ({1'b0, ref_eff_s} < X_HI) | ({1'b0, y_new_s} < Y_HI);
      end
    end
  end

  // Registered cropped output; data holds the last emitted pixel between strobes.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
      out_data_r  <= 16'h0000;
    end else begin
      out_valid_r <= crop_hit_s;
      out_sof_r   <= crop_hit_s & ({1'b0, x_r} == X_LO) & ({1'b0, y_r} == Y_LO);
      out_eol_r   <= crop_hit_s & ({1'b0, x_r} == X_LAST);
      if (crop_hit_s) begin
        out_data_r <= bus.in_data;
      end
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_sof     = out_sof_r;
  assign bus.out_eol     = out_eol_r;
  assign bus.meas_width  = meas_width_r;
  assign bus.meas_height = meas_height_r;
  assign bus.meas_update = meas_update_r;
  assign bus.frame_err   = frame_err_r;

endmodule

// File: tb/tb_cam_frame_crop.sv
// Directed bench for cam_frame_crop: 8-pixel ramp lines cropped to a 4x2 window
// at (2,1), with geometry measurement, malformed frames and mid-line reset.
module tb_cam_frame_crop;
  localparam int CW = 12;

  logic cam_pclk = 1'b0;
  logic cam_data_asy_rst;
  int   total = 0;
  int   bad = 0;
  int   upd_cnt = 0;
  int   idle_viol = 0;
  int   upd_base;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [15:0] data;
  } rx_t;
  rx_t rx_q[$];

  cam_frame_crop_if #(.CW(CW)) cam_if ();

  cam_frame_crop #(
    .X_START(2), .Y_START(1), .CROP_W(4), .CROP_H(2), .CW(CW)
  ) dut (
    .cam_pclk         (cam_pclk),
    .cam_data_asy_rst (cam_data_asy_rst),
    .bus              (cam_if)
  );

  always #5 cam_pclk = ~cam_pclk;

  // Collect the cropped stream and side effects away from the active edge.
  always @(negedge cam_pclk) begin
    if (cam_if.out_valid) begin
      rx_q.push_back({cam_if.out_sof, cam_if.out_eol, cam_if.out_data});
    end else if (cam_if.out_sof || cam_if.out_eol) begin
      idle_viol++;
    end
    if (cam_if.meas_update) upd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  // One pixel: first byte cycle, then the valid cycle; its data shows up next cycle.
  task automatic drive_px(input logic [15:0] d);
    cam_if.in_valid = 1'b0;
    tick();
    cam_if.in_valid = 1'b1;
    tick();
    cam_if.in_data = d;
  endtask

  task automatic send_line(input int y, input int npx);
    cam_if.in_href = 1'b1;
    for (int p = 0; p < npx; p++) drive_px(16'(y * 16 + p));
    cam_if.in_href  = 1'b0;
    cam_if.in_valid = 1'b0;
    tick();
    repeat (3) tick();
  endtask

  task automatic empty_href(input int n);
    cam_if.in_href = 1'b1;
    repeat (n) tick();
    cam_if.in_href = 1'b0;
    repeat (2) tick();
  endtask

  task automatic pulse_vsync();
    cam_if.in_vsync = 1'b1;
    tick();
    cam_if.in_vsync = 1'b0;
  endtask

  task automatic close_frame(input int w, input int h, input int err);
    pulse_vsync();
    chk("upd_pulse", 32'(cam_if.meas_update), 32'd1);
    chk("meas_w", 32'(cam_if.meas_width), 32'(w));
    chk("meas_h", 32'(cam_if.meas_height), 32'(h));
    chk("frame_err", 32'(cam_if.frame_err), 32'(err));
    tick();
    chk("upd_end", 32'(cam_if.meas_update), 32'd0);
  endtask

  task automatic first_vsync();
    upd_base = upd_cnt;
    pulse_vsync();
    tick();
    chk("first_upd", 32'(upd_cnt - upd_base), 32'd0);
    chk("first_err", 32'(cam_if.frame_err), 32'd0);
  endtask

  // Window (2..5) x (1..2) of ramp y*16+x, row-major.
  task automatic check_frame(input string tag);
    chk({tag, "_cnt"}, 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      chk({tag, "_data"}, 32'(rx_q[i].data), 32'((1 + i / 4) * 16 + 2 + i % 4));
      chk({tag, "_sof"}, 32'(rx_q[i].sof), 32'(i == 0));
      chk({tag, "_eol"}, 32'(rx_q[i].eol), 32'(i % 4 == 3));
    end
    rx_q.delete();
  endtask

  task automatic std_frame(input int short_line);
    for (int y = 0; y < 4; y++) send_line(y, (y == short_line) ? 7 : 8);
  endtask

  initial begin
    cam_data_asy_rst = 1'b1;
    cam_if.in_vsync  = 1'b0;
    cam_if.in_href   = 1'b0;
    cam_if.in_valid  = 1'b0;
    cam_if.in_data   = 16'h0000;
    tick();
    chk("rst_valid", 32'(cam_if.out_valid), 32'd0);
    chk("rst_meas_w", 32'(cam_if.meas_width), 32'd0);
    chk("rst_meas_h", 32'(cam_if.meas_height), 32'd0);
    chk("rst_upd", 32'(cam_if.meas_update), 32'd0);
    chk("rst_err", 32'(cam_if.frame_err), 32'd0);
    #5 cam_data_asy_rst = 1'b0;
    repeat (3) tick();

    // Traffic before the first vsync is ignored.
    send_line(0, 8);
    empty_href(2);
    send_line(1, 8);
    chk("pre_sof_cnt", 32'(rx_q.size()), 32'd0);
    rx_q.delete();
    first_vsync();

    std_frame(-1);
    check_frame("frm_a");
    chk("data_hold", 32'(cam_if.out_data), 32'h25);
    close_frame(8, 4, 0);

    std_frame(2);
    check_frame("frm_b");
    close_frame(8, 4, 1);

    std_frame(-1);
    check_frame("frm_c");
    close_frame(8, 4, 0);

    // Single-line frame is too short for the window.
    send_line(0, 8);
    empty_href(1);
    chk("frm_d_cnt", 32'(rx_q.size()), 32'd0);
    rx_q.delete();
    close_frame(8, 1, 1);

    // Empty href pulses between lines must not count as lines.
    empty_href(1);
    send_line(0, 8);
    empty_href(1);
    send_line(1, 8);
    empty_href(4);
    send_line(2, 8);
    empty_href(1);
    check_frame("frm_e");
    close_frame(8, 3, 0);

    // Reset in the middle of a cropped line.
    send_line(0, 8);
    cam_if.in_href = 1'b1;
    drive_px(16'h10);
    drive_px(16'h11);
    drive_px(16'h12);
    cam_if.in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(cam_if.out_valid), 32'd1);
    #2 cam_data_asy_rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(cam_if.out_valid), 32'd0);
    cam_if.in_href = 1'b0;
    repeat (3) tick();
    chk("rst_meas_w2", 32'(cam_if.meas_width), 32'd0);
    #2 cam_data_asy_rst = 1'b0;
    tick();
    // This vsync lands on the second edge after release, still inside reset.
    cam_if.in_vsync = 1'b1;
    tick();
    cam_if.in_vsync = 1'b0;
    rx_q.delete();
    upd_base = upd_cnt;
    send_line(0, 8);
    send_line(1, 8);
    send_line(2, 8);
    chk("post_rst_cnt", 32'(rx_q.size()), 32'd0);
    chk("post_rst_upd", 32'(upd_cnt - upd_base), 32'd0);
    rx_q.delete();
    first_vsync();
    std_frame(-1);
    check_frame("frm_g");
    close_frame(8, 4, 0);

    chk("sof_eol_idle", 32'(idle_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
